// File: rtl/decode_stage_hz.sv
// decode_stage_hz: MiniMIPS instruction-decode stage.
// Holds the IF/ID register, the register file with write-through, the early
// branch comparator with MEM-stage forwarding, and the hazard detector that
// drives the stall/flush controls for fetch and execute.
module decode_stage_hz #(
    parameter int DW     = 32,
    parameter int PW     = 32,
    parameter int NREG   = 32,
    parameter bit EN_BNE = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   InstrF,
    input  logic [PW-1:0] PCPlus4F,
    input  logic          RegWriteE,
    input  logic          MemtoRegE,
    input  logic [4:0]    WriteRegE,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic [4:0]    WriteRegM,
    input  logic [DW-1:0] ALUOutM,
    input  logic          RegWriteW,
    input  logic [4:0]    WriteRegW,
    input  logic [DW-1:0] ResultW,
    output logic [31:0]   InstrD,
    output logic [PW-1:0] PCPlus4D,
    output logic [DW-1:0] RD1D,
    output logic [DW-1:0] RD2D,
    output logic [DW-1:0] SignImmD,
    output logic [PW-1:0] PCBranchD,
    output logic [PW-1:0] PCJumpD,
    output logic [4:0]    RsD,
    output logic [4:0]    RtD,
    output logic [4:0]    RdD,
    output logic          PCSrcD,
    output logic          JumpD,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushE
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    logic [31:0]   instr_q, instr_d;
    logic [PW-1:0] pc4_q, pc4_d;
    logic          flush_d;
    logic          stall;

    // Flush beats stall beats load; a flush injects an all-zero nop.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush_d) begin
            instr_d = '0;
            pc4_d   = '0;
        end else if (!stall) begin
            instr_d = InstrF;
            pc4_d   = PCPlus4F;
        end
    end

    // IF/ID state, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCPlus4D = pc4_q;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]         opcode;
    logic signed [15:0] imm16;
    logic signed [17:0] br_off;

    assign opcode = instr_q[31:26];
    assign RsD    = instr_q[25:21];
    assign RtD    = instr_q[20:16];
    assign RdD    = instr_q[15:11];
    assign imm16  = instr_q[15:0];
    // Word offset kept at 18 bits so the branch target is correct for any DW.
    assign br_off = {instr_q[15:0], 2'b00};

    assign SignImmD  = DW'(imm16);
    assign PCBranchD = pc4_q + PW'(br_off);

    // Jump target keeps the PC region bits only when PW leaves room for them.
    generate
        if (PW > 28) begin : g_jreg
            assign PCJumpD = {pc4_q[PW-1:28], instr_q[25:0], 2'b00};
        end else begin : g_jflat
            assign PCJumpD = {instr_q[25:0], 2'b00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    // Next register state: one W-stage write, r0 and out-of-range indices dropped.
    always_comb begin
        rf_d = rf_q;
        for (int i = 1; i < NREG; i++) begin
            if (RegWriteW && (WriteRegW == 5'(i)))
                rf_d[i] = ResultW;
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= rf_d[i];
        end
    end

    logic [DW-1:0] rd1_arr, rd2_arr;
    logic          rs_ok, rt_ok;

    // Array lookup; r0 and indices beyond NREG fall through to zero.
    always_comb begin
        rd1_arr = '0;
        rd2_arr = '0;
        for (int i = 1; i < NREG; i++) begin
            if (RsD == 5'(i)) rd1_arr = rf_q[i];
            if (RtD == 5'(i)) rd2_arr = rf_q[i];
        end
    end

    assign rs_ok = (RsD != 5'd0) && (int'(RsD) < NREG);
    assign rt_ok = (RtD != 5'd0) && (int'(RtD) < NREG);

    // Write-through: a same-cycle W write to the read register wins.
    always_comb begin
        RD1D = rd1_arr;
        RD2D = rd2_arr;
        if (RegWriteW && rs_ok && (WriteRegW == RsD)) RD1D = ResultW;
        if (RegWriteW && rt_ok && (WriteRegW == RtD)) RD2D = ResultW;
    end

    // ------------------------------------------------------------------
    // Branch comparator with MEM-stage forwarding
    // ------------------------------------------------------------------
    logic          fwd_a, fwd_b;
    logic [DW-1:0] op_a, op_b;
    logic          eq;

    assign fwd_a = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
    assign fwd_b = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
    assign op_a  = fwd_a ? ALUOutM : RD1D;
    assign op_b  = fwd_b ? ALUOutM : RD2D;
    assign eq    = (op_a == op_b);

    // ------------------------------------------------------------------
    // Decode and hazards
    // ------------------------------------------------------------------
    logic beq_d, bne_d, branch_d, j_d;
    logic e_hits, m_hits;
    logic lwstall, brstall;

    assign beq_d    = (opcode == OP_BEQ);
    assign bne_d    = EN_BNE && (opcode == OP_BNE);
    assign branch_d = beq_d || bne_d;
    assign j_d      = (opcode == OP_J);

    // A nonzero E/M destination matching either source operand.
    assign e_hits = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign m_hits = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));

    // Load in E feeding D needs one bubble; a branch also waits for any ALU
    // result still in E and for a load result still in M.
    assign lwstall = MemtoRegE && e_hits;
    assign brstall = branch_d && ((RegWriteE && e_hits) || (MemtoRegM && m_hits));
    assign stall   = lwstall || brstall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // Redirects are suppressed while the instruction is stalled.
    assign PCSrcD  = ((beq_d && eq) || (bne_d && !eq)) && !stall;
    assign JumpD   = j_d && !stall;
    assign flush_d = PCSrcD || JumpD;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: vector table plus directed sequences for the decode stage.
// Instance u1 decodes bne, instance u0 does not; both share all inputs.
module tb_decode_stage_hz;

    logic        CLK, RST;
    logic [31:0] InstrF, PCPlus4F;
    logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
    logic [31:0] ALUOutM, ResultW;

    logic [31:0] instr_d [2];
    logic [31:0] pc4_d   [2];
    logic [31:0] rd1     [2];
    logic [31:0] rd2     [2];
    logic [31:0] simm    [2];
    logic [31:0] pcbr    [2];
    logic [31:0] pcj     [2];
    logic [4:0]  rs      [2];
    logic [4:0]  rt      [2];
    logic [4:0]  rd      [2];
    logic        pcsrc   [2];
    logic        jump    [2];
    logic        stallf  [2];
    logic        stalld  [2];
    logic        flushe  [2];

    int total = 0;
    int bad   = 0;

    decode_stage_hz #(.DW(32), .PW(32), .NREG(32), .EN_BNE(1'b1)) u1 (
        .CLK(CLK), .RST(RST), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .InstrD(instr_d[1]), .PCPlus4D(pc4_d[1]),
        .RD1D(rd1[1]), .RD2D(rd2[1]), .SignImmD(simm[1]), .PCBranchD(pcbr[1]),
        .PCJumpD(pcj[1]), .RsD(rs[1]), .RtD(rt[1]), .RdD(rd[1]),
        .PCSrcD(pcsrc[1]), .JumpD(jump[1]), .StallF(stallf[1]),
        .StallD(stalld[1]), .FlushE(flushe[1])
    );

    decode_stage_hz #(.DW(32), .PW(32), .NREG(32), .EN_BNE(1'b0)) u0 (
        .CLK(CLK), .RST(RST), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .InstrD(instr_d[0]), .PCPlus4D(pc4_d[0]),
        .RD1D(rd1[0]), .RD2D(rd2[0]), .SignImmD(simm[0]), .PCBranchD(pcbr[0]),
        .PCJumpD(pcj[0]), .RsD(rs[0]), .RtD(rt[0]), .RdD(rd[0]),
        .PCSrcD(pcsrc[0]), .JumpD(jump[0]), .StallF(stallf[0]),
        .StallD(stalld[0]), .FlushE(flushe[0])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        rwe;
        logic        mre;
        logic [4:0]  wre;
        logic        rwm;
        logic        mrm;
        logic [4:0]  wrm;
        logic [31:0] alum;
        logic        pcsrc;
        logic        pcsrc0;
        logic        jump;
        logic        stall;
        logic        stall0;
        logic [31:0] simm;
        logic [31:0] pcbr;
        logic [31:0] pcj;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    vec_t vec [13];
    vec_t sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_em();
        RegWriteE = 1'b0; MemtoRegE = 1'b0; WriteRegE = 5'd0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0; ALUOutM = '0;
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] val);
        RegWriteW = 1'b1; WriteRegW = idx; ResultW = val;
        step();
        RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = '0;
    endtask

    // Loads an instruction into D through an intervening nop so no earlier
    // redirect or stall can interfere.
    task automatic load_d(input logic [31:0] ins, input logic [31:0] pc);
        clear_em();
        InstrF = '0; PCPlus4F = '0;
        step();
        InstrF = ins; PCPlus4F = pc;
        step();
    endtask

    task automatic check_outs(input int k, input int n, input vec_t e);
        string p;
        p = $sformatf("v%0d.u%0d.", n, k);
        chk({p, "InstrD"},    instr_d[k], e.instr);
        chk({p, "PCPlus4D"},  pc4_d[k],   e.pc4);
        chk({p, "RsD"},       rs[k],      e.instr[25:21]);
        chk({p, "RtD"},       rt[k],      e.instr[20:16]);
        chk({p, "RdD"},       rd[k],      e.instr[15:11]);
        chk({p, "SignImmD"},  simm[k],    e.simm);
        chk({p, "PCBranchD"}, pcbr[k],    e.pcbr);
        chk({p, "PCJumpD"},   pcj[k],     e.pcj);
        chk({p, "RD1D"},      rd1[k],     e.rd1);
        chk({p, "RD2D"},      rd2[k],     e.rd2);
        chk({p, "JumpD"},     jump[k],    e.jump);
        chk({p, "PCSrcD"},    pcsrc[k],   (k == 1) ? e.pcsrc : e.pcsrc0);
        chk({p, "StallD"},    stalld[k],  (k == 1) ? e.stall : e.stall0);
        chk({p, "StallF"},    stallf[k],  (k == 1) ? e.stall : e.stall0);
        chk({p, "FlushE"},    flushe[k],  (k == 1) ? e.stall : e.stall0);
    endtask

    initial begin
        vec_t e;

        // instr, pc4, rwe, mre, wre, rwm, mrm, wrm, alum,
        // pcsrc, pcsrc0, jump, stall, stall0, simm, pcbr, pcj, rd1, rd2
        vec[0]  = '{32'h10220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 32'd5,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[1]  = '{32'h10220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[2]  = '{32'h14220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[3]  = '{32'h14220003, 32'h100, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[4]  = '{32'h14220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd2, 32'd7,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[5]  = '{32'h00432020, 32'h300, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2020, 32'h8380, 32'h010C8080, 32'd7, 32'd9};
        vec[6]  = '{32'h00432020, 32'h300, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2020, 32'h8380, 32'h010C8080, 32'd7, 32'd9};
        vec[7]  = '{32'h8C220004, 32'h400, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'h410, 32'h00880010, 32'd5, 32'd7};
        vec[8]  = '{32'h08000010, 32'h40000004, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40000044, 32'h40000040, 32'd0, 32'd0};
        vec[9]  = '{32'h1022FFFF, 32'h200, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 32'd5,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1FC, 32'h008BFFFC, 32'd5, 32'd7};
        vec[10] = '{32'h10220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd5,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[11] = '{32'h10220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd1, 32'd7,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};
        vec[12] = '{32'h10220003, 32'h100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd1, 32'd7,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 32'h10C, 32'h0088000C, 32'd5, 32'd7};

        // Reset with a load waiting in fetch.
        RST = 1'b0;
        clear_em();
        RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = '0;
        InstrF = 32'h8C220004; PCPlus4F = 32'h4;
        #1 RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.u%0d.InstrD", k),    instr_d[k], 32'h0);
            chk($sformatf("rst.u%0d.StallD", k),    stalld[k],  1'b0);
            chk($sformatf("rst.u%0d.PCSrcD", k),    pcsrc[k],   1'b0);
            chk($sformatf("rst.u%0d.JumpD", k),     jump[k],    1'b0);
            chk($sformatf("rst.u%0d.PCBranchD", k), pcbr[k],    32'h0);
            chk($sformatf("rst.u%0d.PCJumpD", k),   pcj[k],     32'h0);
        end
        step();
        chk("rst.held.InstrD", instr_d[1], 32'h0);
        RST = 1'b0;
        step();
        chk("rst.rel.InstrD", instr_d[1], 32'h8C220004);
        chk("rst.rel.RsD",    rs[1],      5'd1);
        chk("rst.rel.RtD",    rt[1],      5'd2);
        chk("rst.rel.RD1D",   rd1[1],     32'h0);
        chk("rst.rel.RD2D",   rd2[1],     32'h0);

        InstrF = '0;
        wr_reg(5'd1, 32'd5);
        wr_reg(5'd2, 32'd7);

        // Write-through on r3, then an attempted write to r0.
        load_d(32'h00600000, 32'h10);
        chk("wt.pre.RD1D", rd1[1], 32'h0);
        RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'h55;
        #1 chk("wt.same.RD1D", rd1[1], 32'h55);
        step();
        RegWriteW = 1'b0;
        #1 chk("wt.after.RD1D", rd1[1], 32'h55);
        load_d(32'h00030000, 32'h10);
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFF;
        #1 chk("r0.same.RD1D", rd1[1], 32'h0);
        step();
        RegWriteW = 1'b0;
        #1 chk("r0.after.RD1D", rd1[1], 32'h0);
        chk("r0.after.RD2D", rd2[1], 32'h55);
        wr_reg(5'd3, 32'd9);

        // Vector table through the scoreboard.
        for (int i = 0; i < 13; i++) begin
            load_d(vec[i].instr, vec[i].pc4);
            RegWriteE = vec[i].rwe; MemtoRegE = vec[i].mre; WriteRegE = vec[i].wre;
            RegWriteM = vec[i].rwm; MemtoRegM = vec[i].mrm; WriteRegM = vec[i].wrm;
            ALUOutM = vec[i].alum;
            sb.push_back(vec[i]);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d.sb_empty", i), 1, 0);
            end else begin
                e = sb.pop_front();
                check_outs(1, i, e);
                check_outs(0, i, e);
            end
        end

        // Taken beq squashes exactly the delay-slot fetch.
        load_d(32'h10220003, 32'h100);
        InstrF = 32'h00432020; PCPlus4F = 32'h104;
        RegWriteM = 1'b1; WriteRegM = 5'd2; ALUOutM = 32'd5;
        #1 chk("beq.PCSrcD", pcsrc[1], 1'b1);
        step();
        chk("beq.flush.InstrD",   instr_d[1], 32'h0);
        chk("beq.flush.PCPlus4D", pc4_d[1],   32'h0);

        // Load-use: hold one edge, release when the load leaves E.
        load_d(32'h00432020, 32'h500);
        InstrF = 32'h8C220004; PCPlus4F = 32'h504;
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2;
        #1 chk("lu.StallF", stallf[1], 1'b1);
        step();
        chk("lu.hold.InstrD", instr_d[1], 32'h00432020);
        clear_em();
        #1 chk("lu.rel.StallD", stalld[1], 1'b0);
        step();
        chk("lu.next.InstrD", instr_d[1], 32'h8C220004);

        // bne waits on an ALU producer in E, then resolves taken.
        load_d(32'h14220003, 32'h600);
        InstrF = 32'h00432020; PCPlus4F = 32'h604;
        RegWriteE = 1'b1; WriteRegE = 5'd1;
        #1 chk("bs.StallD", stalld[1], 1'b1);
        chk("bs.PCSrcD", pcsrc[1], 1'b0);
        step();
        chk("bs.hold.InstrD", instr_d[1], 32'h14220003);
        clear_em();
        #1 chk("bs.res.PCSrcD", pcsrc[1], 1'b1);
        step();
        chk("bs.flush.InstrD", instr_d[1], 32'h0);

        // Jump redirects and flushes.
        load_d(32'h08000010, 32'h40000004);
        InstrF = 32'h8C220004; PCPlus4F = 32'h40000008;
        #1 chk("j.JumpD", jump[1], 1'b1);
        chk("j.PCJumpD", pcj[1], 32'h40000040);
        step();
        chk("j.flush.InstrD", instr_d[1], 32'h0);
        chk("j.flush.u0.InstrD", instr_d[0], 32'h0);

        // Asynchronous reset in the middle of a load-use stall.
        load_d(32'h00432020, 32'h700);
        InstrF = 32'h00220000; PCPlus4F = 32'h704;
        MemtoRegE = 1'b1; WriteRegE = 5'd2;
        #1 chk("ar.pre.StallD", stalld[1], 1'b1);
        #1 RST = 1'b1;
        #1 chk("ar.InstrD", instr_d[1], 32'h0);
        chk("ar.StallD", stalld[1], 1'b0);
        #1 RST = 1'b0;
        clear_em();
        step();
        chk("ar.load.InstrD", instr_d[1], 32'h00220000);
        chk("ar.load.RD1D",   rd1[1],     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised instruction-decode stage for the 5-stage MiniMIPS pipeline. It provides:
- the IF/ID pipeline register with stall and flush;
- a write-through register file;
- early branch resolution (beq, and optionally bne) with internal M-stage forwarding;
- the load-use and branch hazard detector.

It sits between the fetch stage and the ID/EX register. It drives the stall/flush controls back to fetch and forward to execute.

## Interface
Parameters:
- DW, 32, data/register width (16..64); immediates sign-extend to DW.
- PW, 32, program-counter width (≥28).
- NREG, 32, number of architectural registers (2..32). Register indices ≥ NREG read as 0; writes to them are ignored.
- EN_BNE, 1, 1 = opcode 6'b000101 (bne) decoded as a branch; 0 = treated as non-branch.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- InstrF  in  32  instruction from fetch.
- PCPlus4F  in  PW  PC+4 from fetch.
- RegWriteE, MemtoRegE  in  1 each  EX-stage control.
- WriteRegE  in  5  EX-stage destination.
- RegWriteM, MemtoRegM  in  1 each  MEM-stage control.
- WriteRegM  in  5  MEM-stage destination.
- ALUOutM  in  DW  MEM-stage ALU result.
- RegWriteW  in  1  writeback enable.
- WriteRegW  in  5  writeback destination.
- ResultW  in  DW  writeback data.
- InstrD  out  32  registered instruction.
- PCPlus4D  out  PW  registered PC+4.
- RD1D, RD2D  out  DW  register-file read data, unforwarded.
- SignImmD  out  DW  sign-extended InstrD[15:0].
- PCBranchD  out  PW  PCPlus4D + (SignImmD<<2), truncated to PW.
- PCJumpD  out  PW  {PCPlus4D[PW-1:28], InstrD[25:0], 2'b00}.
- RsD, RtD, RdD  out  5 each  InstrD[25:21], [20:16], [15:11].
- PCSrcD  out  1  branch taken, qualified.
- JumpD  out  1  jump, qualified.
- StallF, StallD  out  1 each  hold PC / hold IF/ID.
- FlushE  out  1  clear ID/EX register.

## Operation
- **IF/ID register.** Priority order is RST > FlushD > StallD > load.
  - RST: InstrD=0, PCPlus4D=0.
  - FlushD = PCSrcD | JumpD: load InstrD=0 (nop) and PCPlus4D=0 on the next edge.
  - StallD: hold.
  - Otherwise: load InstrF and PCPlus4F.
- **Register file.**
  - Holds NREG×DW. RST clears all entries.
  - Writes at the edge when RegWriteW and 0 < WriteRegW < NREG.
  - Register 0 always reads 0.
  - Reads are combinational, with write-through: if RegWriteW, WriteRegW = Rs (or Rt), and it is nonzero, RD1D (or RD2D) = ResultW in the same cycle.
- **Comparator forwarding.**
  - fwdA = RegWriteM & WriteRegM≠0 & WriteRegM=RsD. The comparator operand is then ALUOutM; otherwise it is RD1D.
  - fwdB is the same with RtD.
  - eq = (opA == opB) over the full DW width.
- **Decode.** opcode = InstrD[31:26].
  - beqD = (opcode=000100).
  - bneD = EN_BNE & (opcode=000101).
  - BranchD = beqD | bneD.
  - jD = (opcode=000010).
- **Hazards.**
  - lwstall = MemtoRegE & (WriteRegE=RsD | WriteRegE=RtD) & WriteRegE≠0.
  - brstall = BranchD & [(RegWriteE & WriteRegE≠0 & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM≠0 & WriteRegM∈{RsD,RtD})].
  - StallD = StallF = FlushE = lwstall | brstall.
- **Outputs.**
  - PCSrcD = ((beqD & eq) | (bneD & ~eq)) & ~StallD.
  - JumpD = jD & ~StallD.
  - PCSrcD and JumpD are never asserted for a stalled instruction.

## Timing
- All outputs except the register-file contents are combinational from InstrD, the pipeline inputs and the register state.
- Reset values:
  - InstrD = 0 and PCPlus4D = 0, which gives RsD/RtD/RdD = 0, SignImmD = 0, PCBranchD = 0, PCJumpD = 0.
  - PCSrcD = JumpD = 0.
  - Stall/flush outputs are 0 under reset: the nop has no hazard, since WriteRegE≠0 is required.
- Branch latency: the branch resolves in the cycle it sits in D. The flush takes effect at the next edge, so exactly one delay-slot fetch is squashed.
- Stall: the instruction is held in D while StallD=1. It resolves when the producer advances; brstall needs at most 2 cycles and lwstall 1.
- Simultaneous W-write and D-read of the same register: the new value is returned.
- Reset asserted mid-stall or mid-flush: state clears immediately and asynchronously. After deassertion, the first edge loads InstrF.

## Test plan
- **Reset:** assert RST with InstrF=0x8C220004 → InstrD=0, all registers 0, StallD=0. Release RST → the next edge gives InstrD=0x8C220004, RsD=1, RtD=2.
- **Write-through and register 0:**
  - RegWriteW=1, WriteRegW=3, ResultW=0x55 with InstrD reading rs=3 → RD1D=0x55 in the same cycle.
  - WriteRegW=0, ResultW=0xFF → r0 reads 0 afterwards.
- **beq with M forwarding:** r1=5, r2=7, InstrD=beq r1,r2 (0x10220003), RegWriteM=1, WriteRegM=2, ALUOutM=5 → PCSrcD=1 and PCBranchD=PCPlus4D+12. The next edge gives InstrD=0.
- **Load-use:** MemtoRegE=1, WriteRegE=2, InstrD=add r4,r2,r3 → StallF=StallD=FlushE=1 and InstrD holds for 1 edge. It releases when MemtoRegE drops.
- **Branch stall and bne:**
  - EN_BNE=1, InstrD=bne r1,r2, RegWriteE=1, WriteRegE=1 → StallD=1 and PCSrcD=0.
  - The next cycle, with no E/M conflicts and r1≠r2 → PCSrcD=1.
  - With EN_BNE=0 → PCSrcD stays 0.
- **Jump:** InstrD=0x08000010, PCPlus4D=0x40000004 → JumpD=1 and PCJumpD=0x40000040. The next edge flushes InstrD to 0.
